// File: rtl/lcd_phrase_writer.sv
// lcd_phrase_writer: sends a phrase of 1..MAX_CHARS bytes to an HD44780
// character LCD over its 4-bit bus, high nibble first. All setup,
// enable-pulse, inter-nibble and post-byte waits come from one cycle counter.
// A byte ends when the wait that follows it has elapsed. Commands 0x01 and
// 0x02 in command mode get the long post-byte wait.
// Optional feature (macro LCD_AUTO_LINE2_EN): in data mode with more than 16
// bytes, command 0xC0 (line-2 DDRAM address) is inserted before byte 16.
module lcd_phrase_writer #(
  parameter int MAX_CHARS     = 16,
  parameter int LEN_W         = 6,
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 12,
  parameter int GAP_CYC       = 50,
  parameter int BYTE_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC = 82000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iStart,
  input  logic                   iRS,
  input  logic [LEN_W-1:0]       iLength,
  input  logic [8*MAX_CHARS-1:0] iData,
  output logic                   oBusy,
  output logic                   oDone,
  output logic [3:0]             oLCD_Data,
  output logic                   oLCD_E,
  output logic                   oLCD_RS,
  output logic                   oLCD_RW
);

  localparam int IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(MAX_CHARS);
  localparam logic [31:0]      SETUP_LAST = 32'(SETUP_CYC - 1);
  localparam logic [31:0]      PULSE_LAST = 32'(PULSE_CYC - 1);
  localparam logic [31:0]      GAP_LAST   = 32'(GAP_CYC - 1);
  localparam logic [31:0]      BYTE_LAST  = 32'(BYTE_WAIT_CYC - 1);
  localparam logic [31:0]      LONG_LAST  = 32'(LONG_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP_HI,
    PULSE_HI,
    GAP,
    SETUP_LO,
    PULSE_LO,
    WAIT_BYTE,
    DONE
  } state_t;

  state_t                       state, state_n;
  logic [31:0]                  count, count_n;
  logic [LEN_W-1:0]             index, index_n;
  logic [LEN_W-1:0]             len, len_n;
  logic [LEN_W-1:0]             len_cap;
  logic [LEN_W-1:0]             index_inc;
  logic [MAX_CHARS-1:0][7:0]    phrase;
  logic                         rs_lat, rs_lat_n;
  logic                         ins, ins_n;
  logic                         load;
  logic [IDX_W-1:0]             sel;
  logic [7:0]                   cur_byte;
  logic                         cur_rs;
  logic [31:0]                  wait_last;
  logic                         busy_n, done_n, e_n, rs_n;
  logic [3:0]                   data_n;

  assign len_cap   = (iLength > MAX_LEN) ? MAX_LEN : iLength;
  assign index_inc = index + 1'b1;
  assign sel       = index[IDX_W-1:0];
  assign cur_byte  = ins ? 8'hC0 : phrase[sel];
  assign cur_rs    = ins ? 1'b0 : rs_lat;
  assign wait_last = (!cur_rs && (cur_byte == 8'h01 || cur_byte == 8'h02)) ? LONG_LAST : BYTE_LAST;
  assign oLCD_RW   = 1'b0;

  // Next-state, counter/index bookkeeping and the next value of every output
  always_comb begin
    state_n  = state;
    count_n  = count + 32'd1;
    index_n  = index;
    len_n    = len;
    rs_lat_n = rs_lat;
    ins_n    = ins;
    load     = 1'b0;
    busy_n   = 1'b1;
    done_n   = 1'b0;
    e_n      = 1'b0;
    data_n   = cur_byte[7:4];
    rs_n     = cur_rs;
    case (state)
      IDLE: begin
        busy_n  = 1'b0;
        data_n  = 4'h0;
        rs_n    = 1'b0;
        count_n = 32'd0;
        if (iStart) begin
          load     = 1'b1;
          len_n    = len_cap;
          rs_lat_n = iRS;
          index_n  = '0;
          ins_n    = 1'b0;
          state_n  = (len_cap == '0) ? DONE : SETUP_HI;
        end
      end
      SETUP_HI: begin
        if (count == SETUP_LAST) begin
          state_n = PULSE_HI;
          count_n = 32'd0;
        end
      end
      PULSE_HI: begin
        e_n = 1'b1;
        if (count == PULSE_LAST) begin
          state_n = GAP;
          count_n = 32'd0;
        end
      end
      GAP: begin
        if (count == GAP_LAST) begin
          state_n = SETUP_LO;
          count_n = 32'd0;
        end
      end
      SETUP_LO: begin
        data_n = cur_byte[3:0];
        if (count == SETUP_LAST) begin
          state_n = PULSE_LO;
          count_n = 32'd0;
        end
      end
      PULSE_LO: begin
        data_n = cur_byte[3:0];
        e_n    = 1'b1;
        if (count == PULSE_LAST) begin
          state_n = WAIT_BYTE;
          count_n = 32'd0;
        end
      end
      WAIT_BYTE: begin
        data_n = cur_byte[3:0];
        if (count == wait_last) begin
          count_n = 32'd0;
          if (ins) begin
            ins_n   = 1'b0;
            state_n = SETUP_HI;
          end else begin
            index_n = index_inc;
            if (index_inc == len) begin
              state_n = DONE;
            end else begin
              state_n = SETUP_HI;
`ifdef LCD_AUTO_LINE2_EN
              if (rs_lat && (len > LEN_W'(16)) && (index_inc == LEN_W'(16))) begin
                ins_n = 1'b1;
              end
`endif
            end
          end
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        data_n  = 4'h0;
        rs_n    = 1'b0;
        count_n = 32'd0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        count_n = 32'd0;
      end
    endcase
  end

  // State register with counter, byte index, phrase length and mode flags
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      count  <= 32'd0;
      index  <= '0;
      len    <= '0;
      rs_lat <= 1'b0;
      ins    <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      index  <= index_n;
      len    <= len_n;
      rs_lat <= rs_lat_n;
      ins    <= ins_n;
    end
  end

  // Phrase capture at start acceptance so later input changes cannot leak in
  always_ff @(posedge Clock) begin
    if (load) begin
      phrase <= iData;
    end
  end

  // Registered bus and handshake outputs, cleared immediately by reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oLCD_E    <= 1'b0;
      oLCD_Data <= 4'h0;
      oLCD_RS   <= 1'b0;
    end else begin
      oBusy     <= busy_n;
      oDone     <= done_n;
      oLCD_E    <= e_n;
      oLCD_Data <= data_n;
      oLCD_RS   <= rs_n;
    end
  end

endmodule

// File: tb/tb_lcd_phrase_writer.sv
// Testbench for lcd_phrase_writer: random and directed phrases checked
// against a transaction-level model of the expected LCD bus activity.
module tb_lcd_phrase_writer;

  localparam int MAXC  = 20;
  localparam int LW    = 6;
  localparam int S     = 2;
  localparam int P     = 12;
  localparam int G     = 50;
  localparam int BW    = 40;
  localparam int LWAIT = 300;
  localparam int DW    = 8 * MAXC;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iStart;
  logic          iRS;
  logic [LW-1:0] iLength;
  logic [DW-1:0] iData;
  logic          oBusy;
  logic          oDone;
  logic [3:0]    oLCD_Data;
  logic          oLCD_E;
  logic          oLCD_RS;
  logic          oLCD_RW;

  lcd_phrase_writer #(
    .MAX_CHARS(MAXC), .LEN_W(LW), .SETUP_CYC(S), .PULSE_CYC(P),
    .GAP_CYC(G), .BYTE_WAIT_CYC(BW), .LONG_WAIT_CYC(LWAIT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iRS(iRS),
    .iLength(iLength), .iData(iData), .oBusy(oBusy), .oDone(oDone),
    .oLCD_Data(oLCD_Data), .oLCD_E(oLCD_E), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW)
  );

  always #10 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge
  logic       prev_e = 1'b0;
  int         rise_cyc[$];
  logic [3:0] rise_nib[$];
  logic       rise_rs[$];
  int         e_high = 0, busy_cnt = 0, done_cnt = 0, done_at = -1, hold_bad = 0, rw_bad = 0;
  logic [3:0] cur_nib = 4'h0;
  logic       cur_rs = 1'b0;

  always @(negedge Clock) begin
    if (oLCD_E && !prev_e) begin
      rise_cyc.push_back(cyc);
      rise_nib.push_back(oLCD_Data);
      rise_rs.push_back(oLCD_RS);
      cur_nib = oLCD_Data;
      cur_rs  = oLCD_RS;
    end else if (oLCD_E && (oLCD_Data !== cur_nib || oLCD_RS !== cur_rs)) begin
      hold_bad++;
    end
    if (oLCD_E) e_high++;
    if (oBusy) busy_cnt++;
    if (oDone) begin
      done_cnt++;
      done_at = cyc;
    end
    if (oLCD_RW !== 1'b0) rw_bad++;
    prev_e = oLCD_E;
  end

  task automatic clearMonitor();
    rise_cyc.delete();
    rise_nib.delete();
    rise_rs.delete();
    e_high = 0; busy_cnt = 0; done_cnt = 0; done_at = -1; hold_bad = 0; rw_bad = 0;
  endtask

  // Drives a one-cycle start; k is the index of the edge that samples it
  task automatic applyStimulus(input logic rs, input int len, input logic [DW-1:0] data, output int k);
    @(posedge Clock);
    #1 clearMonitor();
    @(negedge Clock);
    iStart  = 1'b1;
    iRS     = rs;
    iLength = LW'(len);
    iData   = data;
    k = cyc + 1;
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  task automatic runPhrase(input string name, input logic rs, input int len,
                           input logic [DW-1:0] data, input bit disturb);
    logic [7:0] tb_byte[$];
    logic       tb_rs[$];
    int exp_rise[$];
    logic [3:0] exp_nib[$];
    logic exp_rs[$];
    int nlen, t, w, k, total;
    logic [7:0] b;
    nlen = (len > MAXC) ? MAXC : len;
    for (int i = 0; i < nlen; i++) begin
`ifdef LCD_AUTO_LINE2_EN
      if (rs && nlen > 16 && i == 16) begin
        tb_byte.push_back(8'hC0);
        tb_rs.push_back(1'b0);
      end
`endif
      b = data[i*8 +: 8];
      tb_byte.push_back(b);
      tb_rs.push_back(rs);
    end
    t = S + 1;
    foreach (tb_byte[j]) begin
      w = (!tb_rs[j] && (tb_byte[j] == 8'h01 || tb_byte[j] == 8'h02)) ? LWAIT : BW;
      exp_rise.push_back(t);
      exp_nib.push_back(tb_byte[j][7:4]);
      exp_rs.push_back(tb_rs[j]);
      exp_rise.push_back(t + P + G + S);
      exp_nib.push_back(tb_byte[j][3:0]);
      exp_rs.push_back(tb_rs[j]);
      t += 2 * (S + P) + G + w;
    end
    total = tb_byte.size() == 0 ? 0 : t - (S + 1);

    applyStimulus(rs, len, data, k);
    for (int n = 0; n < total + 20 && done_cnt == 0; n++) begin
      @(negedge Clock);
      if (disturb && total > 40) begin
        if (cyc == k + 30) begin
          iStart  = 1'b1;
          iRS     = ~rs;
          iLength = LW'($urandom_range(0, MAXC));
          for (int i = 0; i < MAXC; i++) iData[i*8 +: 8] = 8'($urandom_range(0, 255));
        end
        if (cyc == k + 31) iStart = 1'b0;
        if (cyc == k + total - 1) iStart = 1'b1;
        if (cyc == k + total) iStart = 1'b0;
      end
    end
    iStart = 1'b0;
    repeat (6) @(negedge Clock);

    checkOutput({name, ".done_count"}, done_cnt, 1);
    checkOutput({name, ".done_cycle"}, done_at - k, total + 1);
    checkOutput({name, ".busy_cycles"}, busy_cnt, total);
    checkOutput({name, ".rise_count"}, rise_cyc.size(), exp_rise.size());
    checkOutput({name, ".e_high_cycles"}, e_high, exp_rise.size() * P);
    checkOutput({name, ".hold_violations"}, hold_bad, 0);
    checkOutput({name, ".rw_nonzero"}, rw_bad, 0);
    for (int j = 0; j < exp_rise.size() && j < rise_cyc.size(); j++) begin
      checkOutput($sformatf("%s.rise%0d_time", name, j), rise_cyc[j] - k, exp_rise[j]);
      checkOutput($sformatf("%s.rise%0d_nib", name, j), rise_nib[j], exp_nib[j]);
      checkOutput($sformatf("%s.rise%0d_rs", name, j), rise_rs[j], exp_rs[j]);
    end
  endtask

  task automatic randomData(output logic [DW-1:0] d);
    logic [7:0] b;
    for (int i = 0; i < MAXC; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 2));
      d[i*8 +: 8] = b;
    end
  endtask

  task automatic resetMidPhrase();
    logic [DW-1:0] d;
    int k;
    randomData(d);
    applyStimulus(1'b1, 3, d, k);
    while (cyc < k + S + P + G + S + 1 + 3) @(negedge Clock);
    checkOutput("rst.e_before", oLCD_E, 1);
    Reset = 1'b1;
    @(negedge Clock);
    checkOutput("rst.e_after", oLCD_E, 0);
    checkOutput("rst.busy_after", oBusy, 0);
    checkOutput("rst.data_after", oLCD_Data, 0);
    checkOutput("rst.done_after", oDone, 0);
    Reset = 1'b0;
    @(posedge Clock);
    #1 clearMonitor();
    repeat (300) @(negedge Clock);
    checkOutput("rst.no_done", done_cnt, 0);
    checkOutput("rst.no_rise", rise_cyc.size(), 0);
    checkOutput("rst.no_busy", busy_cnt, 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    Reset = 1'b1; iStart = 1'b0; iRS = 1'b0; iLength = '0; iData = '0;
    repeat (3) @(negedge Clock);
    checkOutput("reset.busy", oBusy, 0);
    checkOutput("reset.done", oDone, 0);
    checkOutput("reset.e", oLCD_E, 0);
    checkOutput("reset.data", oLCD_Data, 0);
    checkOutput("reset.rs", oLCD_RS, 0);
    checkOutput("reset.rw", oLCD_RW, 0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    d = '0; d[7:0] = 8'h41;
    runPhrase("data_A", 1'b1, 1, d, 1'b0);
    d = '0; d[7:0] = 8'h01;
    runPhrase("cmd_clear", 1'b0, 1, d, 1'b0);
    d = '0; d[7:0] = 8'h02;
    runPhrase("cmd_home", 1'b0, 1, d, 1'b0);
    d = '0; d[23:0] = 24'h214948;
    runPhrase("hi_bang", 1'b1, 3, d, 1'b0);
    randomData(d);
    runPhrase("len_zero", 1'b1, 0, d, 1'b0);
    randomData(d);
    runPhrase("len_over", 1'b1, 40, d, 1'b0);
    randomData(d);
    runPhrase("len_17_data", 1'b1, 17, d, 1'b0);
    randomData(d);
    runPhrase("len_17_cmd", 1'b0, 17, d, 1'b0);
    randomData(d);
    runPhrase("disturb", 1'b1, 4, d, 1'b1);
    resetMidPhrase();
    d = '0; d[7:0] = 8'h41;
    runPhrase("after_reset", 1'b1, 1, d, 1'b0);

    for (int r = 0; r < 12; r++) begin
      randomData(d);
      runPhrase($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
                $urandom_range(0, MAXC + 4), d, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
